// File: rtl/spad_fifo_pk_if.sv
// Handshake/data bundle for spad_fifo_pk: the master side drives push/pop/peek requests,
// the slave (the FIFO) returns pop data, peek data and status.
interface spad_fifo_pk_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned CNT_WIDTH  = 4
);
  logic                  i_clear;
  logic                  i_write_en;
  logic [DATA_WIDTH-1:0] i_data_in;
  logic                  i_pop_en;
  logic [ADDR_WIDTH-1:0] i_peek_idx;
  logic [DATA_WIDTH-1:0] o_pop_out;
  logic                  o_pop_valid;
  logic [DATA_WIDTH-1:0] o_peek_data;
  logic                  o_peek_valid;
  logic [CNT_WIDTH-1:0]  o_count;
  logic                  o_empty;
  logic                  o_full;
  logic                  o_almost_empty;
  logic                  o_almost_full;
  logic                  o_overflow;
  logic                  o_underflow;

  modport master (
    output i_clear, i_write_en, i_data_in, i_pop_en, i_peek_idx,
    input  o_pop_out, o_pop_valid, o_peek_data, o_peek_valid, o_count,
    input  o_empty, o_full, o_almost_empty, o_almost_full, o_overflow, o_underflow
  );

  modport slave (
    input  i_clear, i_write_en, i_data_in, i_pop_en, i_peek_idx,
    output o_pop_out, o_pop_valid, o_peek_data, o_peek_valid, o_count,
    output o_empty, o_full, o_almost_empty, o_almost_full, o_overflow, o_underflow
  );
endinterface

// File: rtl/spad_fifo_pk.sv
// Scratchpad FIFO with occupancy counter, registered pop, indexed combinational peek,
// programmable almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module spad_fifo_pk #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned AFULL_TH   = DEPTH - 1,
  parameter int unsigned AEMPTY_TH  = 1,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input logic           i_clk,
  input logic           i_rst,
  spad_fifo_pk_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] FullCnt   = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] AfullCnt  = CNT_WIDTH'(AFULL_TH);
  localparam logic [CNT_WIDTH-1:0] AemptyCnt = CNT_WIDTH'(AEMPTY_TH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
  logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [DATA_WIDTH-1:0] pop_out_q, pop_out_d;
  logic                  pop_valid_q, pop_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  flush;
  logic                  pop_ok;
  logic                  push_ok;
  logic [ADDR_WIDTH-1:0] peek_addr;
  logic                  peek_valid;

  assign flush  = i_rst | bus.i_clear;
  assign pop_ok = bus.i_pop_en & (count_q != '0);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign push_ok = bus.i_write_en & ((count_q != FullCnt) | pop_ok);

  always_comb begin
    w_ptr_d     = w_ptr_q;
    r_ptr_d     = r_ptr_q;
    count_d     = count_q;
    pop_out_d   = pop_out_q;
    pop_valid_d = pop_ok;
    overflow_d  = overflow_q | (bus.i_write_en & ~push_ok);
    underflow_d = underflow_q | (bus.i_pop_en & ~pop_ok);

    if (push_ok) begin
      w_ptr_d = w_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      pop_out_d = mem_q[r_ptr_q];
      r_ptr_d   = r_ptr_q + 1'b1;
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (flush) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      count_q     <= '0;
      pop_out_q   <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      count_q     <= count_d;
      pop_out_q   <= pop_out_d;
      pop_valid_q <= pop_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; a flush only discards the push requested in the same cycle.
  always_ff @(posedge i_clk) begin
    if (push_ok && !flush) begin
      mem_q[w_ptr_q] <= bus.i_data_in;
    end
  end

  assign peek_addr  = r_ptr_q + bus.i_peek_idx;
  assign peek_valid = CNT_WIDTH'(bus.i_peek_idx) < count_q;

  assign bus.o_peek_data    = peek_valid ? mem_q[peek_addr] : '0;
  assign bus.o_peek_valid   = peek_valid;
  assign bus.o_pop_out      = pop_out_q;
  assign bus.o_pop_valid    = pop_valid_q;
  assign bus.o_count        = count_q;
  assign bus.o_empty        = (count_q == '0);
  assign bus.o_full         = (count_q == FullCnt);
  assign bus.o_almost_full  = (count_q >= AfullCnt);
  assign bus.o_almost_empty = (count_q <= AemptyCnt);
  assign bus.o_overflow     = overflow_q;
  assign bus.o_underflow    = underflow_q;

endmodule

// File: tb/tb_spad_fifo_pk.sv
// Directed bench for spad_fifo_pk: a queue-based reference model checked every cycle,
// plus literal expectations at the scenario points.
module tb_spad_fifo_pk;
  localparam int unsigned Depth = 8;
  localparam int unsigned Dw    = 8;
  localparam int unsigned Aw    = 3;
  localparam int unsigned Cw    = 4;
  localparam int unsigned AfTh  = Depth - 1;
  localparam int unsigned AeTh  = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  bit   cmp_en = 1'b0;

  spad_fifo_pk_if #(.DATA_WIDTH(Dw), .ADDR_WIDTH(Aw), .CNT_WIDTH(Cw)) bus ();

  spad_fifo_pk #(
    .DEPTH(Depth), .DATA_WIDTH(Dw), .AFULL_TH(AfTh), .AEMPTY_TH(AeTh),
    .ADDR_WIDTH(Aw), .CNT_WIDTH(Cw)
  ) u_dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of stored entries.
  logic [Dw-1:0] q[$];
  logic [Dw-1:0] m_pop_out = '0;
  bit            m_pop_valid = 1'b0;
  bit            m_ovf = 1'b0;
  bit            m_unf = 1'b0;

  always @(posedge clk) begin
    bit p_ok, w_ok;
    if (rst || bus.i_clear) begin
      q.delete();
      m_pop_out   = '0;
      m_pop_valid = 1'b0;
      m_ovf       = 1'b0;
      m_unf       = 1'b0;
    end else begin
      p_ok = bus.i_pop_en && (q.size() != 0);
      w_ok = bus.i_write_en && ((q.size() != Depth) || p_ok);
      m_pop_valid = p_ok;
      if (p_ok) m_pop_out = q.pop_front();
      if (w_ok) q.push_back(bus.i_data_in);
      if (bus.i_write_en && !w_ok) m_ovf = 1'b1;
      if (bus.i_pop_en && !p_ok) m_unf = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int n, idx;
    logic [Dw-1:0] pd;
    if (cmp_en) begin
      n   = q.size();
      idx = int'(bus.i_peek_idx);
      pd  = (idx < n) ? q[idx] : '0;
      check("m_count", 32'(bus.o_count), 32'(n));
      check("m_empty", 32'(bus.o_empty), 32'(n == 0));
      check("m_full", 32'(bus.o_full), 32'(n == Depth));
      check("m_afull", 32'(bus.o_almost_full), 32'(n >= AfTh));
      check("m_aempty", 32'(bus.o_almost_empty), 32'(n <= AeTh));
      check("m_ovf", 32'(bus.o_overflow), 32'(m_ovf));
      check("m_unf", 32'(bus.o_underflow), 32'(m_unf));
      check("m_pop_valid", 32'(bus.o_pop_valid), 32'(m_pop_valid));
      check("m_pop_out", 32'(bus.o_pop_out), 32'(m_pop_out));
      check("m_peek_valid", 32'(bus.o_peek_valid), 32'(idx < n));
      check("m_peek_data", 32'(bus.o_peek_data), 32'(pd));
    end
  end

  // One clock of stimulus; outputs are stable #1 after the edge on return.
  task automatic cyc(input logic we, input logic [Dw-1:0] d, input logic pop, input logic clr);
    bus.i_write_en = we;
    bus.i_data_in  = d;
    bus.i_pop_en   = pop;
    bus.i_clear    = clr;
    @(posedge clk);
    #1;
    bus.i_write_en = 1'b0;
    bus.i_pop_en   = 1'b0;
    bus.i_clear    = 1'b0;
  endtask

  initial begin
    bus.i_write_en = 1'b0;
    bus.i_data_in  = '0;
    bus.i_pop_en   = 1'b0;
    bus.i_clear    = 1'b0;
    bus.i_peek_idx = '0;

    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cmp_en = 1'b1;
    cyc(1'b1, 8'h99, 1'b1, 1'b0);
    rst = 1'b0;
    check("rst_count", 32'(bus.o_count), 0);
    check("rst_empty", 32'(bus.o_empty), 1);
    check("rst_aempty", 32'(bus.o_almost_empty), 1);
    check("rst_pop_out", 32'(bus.o_pop_out), 0);
    check("rst_peek_valid", 32'(bus.o_peek_valid), 0);

    // Fill, then overflow.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      if (i == 6) begin
        check("fill_afull7", 32'(bus.o_almost_full), 1);
        check("fill_full7", 32'(bus.o_full), 0);
      end
    end
    check("fill_count", 32'(bus.o_count), 8);
    check("fill_full", 32'(bus.o_full), 1);
    cyc(1'b1, 8'hFF, 1'b0, 1'b0);
    check("ovf_set", 32'(bus.o_overflow), 1);
    check("ovf_count", 32'(bus.o_count), 8);

    // Drain past empty.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      check("drain_valid", 32'(bus.o_pop_valid), 1);
      check("drain_data", 32'(bus.o_pop_out), 32'(8'h10 + i));
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("unf_set", 32'(bus.o_underflow), 1);
    check("unf_hold", 32'(bus.o_pop_out), 32'h17);
    check("unf_valid", 32'(bus.o_pop_valid), 0);

    // Clear flags, then push+pop while full.
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_ovf", 32'(bus.o_overflow), 0);
    check("clr_unf", 32'(bus.o_underflow), 0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'hAA, 1'b1, 1'b0);
    check("fpp_data", 32'(bus.o_pop_out), 32'h50);
    check("fpp_count", 32'(bus.o_count), 8);
    check("fpp_ovf", 32'(bus.o_overflow), 0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      check("fpp_drain", 32'(bus.o_pop_out), (i == 7) ? 32'hAA : 32'(8'h51 + i));
    end

    // Wrap and peek.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      bus.i_peek_idx = 3'(i);
      #1;
      check("peek_valid", 32'(bus.o_peek_valid), (i < 7) ? 1 : 0);
      check("peek_data", 32'(bus.o_peek_data), (i < 7) ? 32'(8'h20 + i) : 0);
    end
    bus.i_peek_idx = '0;
    for (int i = 0; i < 7; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Push+pop while empty.
    cyc(1'b1, 8'h33, 1'b1, 1'b0);
    check("epp_count", 32'(bus.o_count), 1);
    check("epp_unf", 32'(bus.o_underflow), 1);
    check("epp_valid", 32'(bus.o_pop_valid), 0);
    check("epp_peek", 32'(bus.o_peek_data), 32'h33);

    // Clear mid-stream with push+pop in the same cycle.
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h34 + i), 1'b0, 1'b0);
    check("pre_clr_count", 32'(bus.o_count), 4);
    cyc(1'b1, 8'hEE, 1'b1, 1'b1);
    check("mclr_count", 32'(bus.o_count), 0);
    check("mclr_unf", 32'(bus.o_underflow), 0);
    check("mclr_pop_out", 32'(bus.o_pop_out), 0);
    check("mclr_valid", 32'(bus.o_pop_valid), 0);
    cyc(1'b1, 8'h44, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("mclr_pop44", 32'(bus.o_pop_out), 32'h44);
    check("mclr_valid44", 32'(bus.o_pop_valid), 1);

    // Reset during a push behaves like clear.
    cyc(1'b1, 8'h01, 1'b0, 1'b0);
    rst = 1'b1;
    cyc(1'b1, 8'h02, 1'b1, 1'b0);
    rst = 1'b0;
    check("rst_mid_count", 32'(bus.o_count), 0);
    check("rst_mid_pop_out", 32'(bus.o_pop_out), 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spad_fifo_pk.md
# spad_fifo_pk

Parametrised scratchpad FIFO with an explicit occupancy counter, registered pop with valid strobe, indexed combinational peek into any stored entry, programmable almost-full/almost-empty thresholds and sticky overflow/underflow flags. It replaces the basic spad FIFO between the operand loaders and the PE-array feeders. Feeders can look ahead up to DEPTH entries for window reuse without popping. All DEPTH slots are usable; full and empty are never ambiguous.

## Interface
- DEPTH, 8: number of entries; power of two, ≥ 2.
- DATA_WIDTH, 8: entry width in bits.
- AFULL_TH, DEPTH-1: o_almost_full asserts when count ≥ AFULL_TH; range 1..DEPTH.
- AEMPTY_TH, 1: o_almost_empty asserts when count ≤ AEMPTY_TH; range 0..DEPTH-1.
- ADDR_WIDTH, $clog2(DEPTH): pointer and peek-index width.
- CNT_WIDTH, $clog2(DEPTH)+1: occupancy width.

Ports:
- i_clk  in  1  clock; one clock, all logic on the rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_clear  in  1  synchronous flush; same effect as reset on all state.
- i_write_en  in  1  push request.
- i_data_in  in  DATA_WIDTH  push data.
- i_pop_en  in  1  pop request.
- o_pop_out  out  DATA_WIDTH  popped entry, registered.
- o_pop_valid  out  1  one-cycle strobe: o_pop_out was updated by an accepted pop.
- i_peek_idx  in  ADDR_WIDTH  offset from head (0 = oldest).
- o_peek_data  out  DATA_WIDTH  entry at head+i_peek_idx, combinational.
- o_peek_valid  out  1  i_peek_idx < count.
- o_count  out  CNT_WIDTH  current occupancy, 0..DEPTH.
- o_empty, o_full, o_almost_empty, o_almost_full  out  1 each  status.
- o_overflow, o_underflow  out  1 each  sticky error flags.

## Operation
- State: w_ptr, r_ptr (ADDR_WIDTH, wrap modulo DEPTH), count (CNT_WIDTH), storage array (not reset), o_pop_out, o_pop_valid, sticky flags.
- Pop accepted (pop_ok) = i_pop_en & (count != 0).
- Push accepted (push_ok) = i_write_en & ((count != DEPTH) | pop_ok). When full, a simultaneous pop frees the slot, so both are accepted.
- push_ok: mem[w_ptr] ← i_data_in; w_ptr+1.
- pop_ok: o_pop_out ← mem[r_ptr]; r_ptr+1; o_pop_valid ← 1.
- No pop: o_pop_out holds its value; o_pop_valid ← 0.
- Count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Empty + push + pop: the pop is rejected with no fall-through; the push is accepted; o_underflow is set.
- i_write_en while full and no pop_ok: the write is dropped, storage is unchanged, o_overflow ← 1.
- i_pop_en while empty: no change to o_pop_out, o_pop_valid ← 0, o_underflow ← 1.
- Sticky flags clear only on i_rst or i_clear.
- Peek: o_peek_data = mem[(r_ptr + i_peek_idx) mod DEPTH] when o_peek_valid, else 0. Peek never changes state.
- Status, combinational from the registered count:
  - o_empty = (count==0); o_full = (count==DEPTH).
  - o_almost_full = (count ≥ AFULL_TH); o_almost_empty = (count ≤ AEMPTY_TH).
- i_rst or i_clear: w_ptr, r_ptr, count ← 0; o_pop_out ← 0; o_pop_valid ← 0; o_overflow, o_underflow ← 0. This takes priority over push and pop in the same cycle, and those requests are discarded. Reset during any operation behaves identically.
- No $monitor or simulation-only output in the RTL.

## Timing
- Values after reset/clear: o_pop_out=0, o_pop_valid=0, o_count=0, o_empty=1, o_full=0, o_almost_empty=1 (AEMPTY_TH≥0), o_almost_full=0, o_overflow=0, o_underflow=0, o_peek_valid=0, o_peek_data=0.
- Push in cycle N: visible in o_count, status and peek after edge N+1.
- Pop latency is 1: i_pop_en sampled at edge N gives o_pop_out and o_pop_valid valid after edge N, for one cycle.
- Peek is zero-latency from i_peek_idx and the current pointers. A pop at edge N shifts the peek window by one after edge N.
- Sustained simultaneous push/pop gives 1 entry/cycle throughput at any occupancy, including full.
- Status, o_count, o_peek_valid and o_peek_data are combinational from registers and i_peek_idx; there is no path from i_write_en or i_pop_en.

## Test plan
- Reset then fill (DEPTH=8): push 0x10..0x17 → o_count=8, o_full=1, o_almost_full=1 from count 7. A 9th push of 0xFF sets o_overflow; the following pops return 0x10..0x17 and never 0xFF.
- Drain past empty: pop 8 → o_pop_valid pulses 8 times with 0x10..0x17 one cycle after each request. A 9th pop sets o_underflow; o_pop_out holds 0x17 and o_pop_valid=0.
- Full push+pop: at count=8, push 0xAA with pop in the same cycle → o_pop_out=head, count stays 8, no overflow. 0xAA is returned as the 8th subsequent pop.
- Wrap and peek: push 5, pop 5, push 0x20..0x26 → peek idx 0..6 = 0x20..0x26 with valid=1; idx 7 → valid=0, data=0.
- Empty push+pop: count=0, push 0x33 with pop → count=1, o_underflow=1, o_pop_valid=0, peek idx0=0x33.
- Clear mid-stream: count=4 and i_clear asserted with push+pop in the same cycle → count=0, all flags 0, o_pop_out=0. The next push of 0x44 followed by a pop returns 0x44.
